// File: rtl/txn_scheduler_if.sv
// Requester and balance-memory signal bundle for txn_scheduler.
// slave = the scheduler itself, master = terminals plus balance store.
interface txn_scheduler_if #(
   parameter int NREQ = 2
) ();
   logic [NREQ-1:0]    req;
   logic [2*NREQ-1:0]  op;
   logic [4*NREQ-1:0]  src_idx;
   logic [4*NREQ-1:0]  dst_idx;
   logic [11*NREQ-1:0] amount;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic [2:0]         resp_code;
   logic [15:0]        resp_balance;
   logic               busy;
   logic               mem_rd;
   logic               mem_wr;
   logic [3:0]         mem_addr;
   logic [15:0]        mem_wdata;
   logic [15:0]        mem_rdata;

   modport slave (
      input  req, op, src_idx, dst_idx, amount, mem_rdata,
      output gnt, done, resp_code, resp_balance, busy,
             mem_rd, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output req, op, src_idx, dst_idx, amount, mem_rdata,
      input  gnt, done, resp_code, resp_balance, busy,
             mem_rd, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/txn_scheduler.sv
// Round-robin transaction scheduler doing atomic read-modify-write on a shared balance memory.
// Optional per-debit fee is enabled by defining TXN_FEE_EN.
module txn_scheduler #(
   parameter int NREQ = 2,
   parameter int NACC = 10,
   parameter int FEE  = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   txn_scheduler_if.slave bus
);

   localparam int PW = (NREQ > 2) ? 2 : 1;

   localparam logic [1:0] OP_BAL = 2'd0;
   localparam logic [1:0] OP_WD  = 2'd1;
   localparam logic [1:0] OP_DEP = 2'd2;
   localparam logic [1:0] OP_XFR = 2'd3;

   localparam logic [2:0] RC_OK       = 3'd0;
   localparam logic [2:0] RC_BAD_IDX  = 3'd1;
   localparam logic [2:0] RC_NO_FUNDS = 3'd2;
   localparam logic [2:0] RC_OVERFLOW = 3'd3;
   localparam logic [2:0] RC_SAME_ACC = 3'd4;

`ifdef TXN_FEE_EN
   localparam bit FEE_ON = 1'b1;
`else
   localparam bit FEE_ON = 1'b0;
`endif
   localparam logic [16:0] FEE_AMT = FEE_ON ? 17'(FEE) : 17'd0;

   typedef enum logic [2:0] {
      ST_IDLE, ST_RD_SRC, ST_RD_DST, ST_EXEC, ST_WR_SRC, ST_WR_DST, ST_RESP
   } state_t;

   state_t            state_r;
   logic [PW-1:0]     rr_ptr_r;
   logic [PW-1:0]     win_r;
   logic [1:0]        op_r;
   logic [3:0]        src_r;
   logic [3:0]        dst_r;
   logic [10:0]       amt_r;
   logic [15:0]       src_bal_r;
   logic [15:0]       new_src_r;
   logic [15:0]       new_dst_r;
   logic [NREQ-1:0]   gnt_r;
   logic [NREQ-1:0]   done_r;
   logic [2:0]        resp_code_r;
   logic [15:0]       resp_balance_r;
   logic              busy_r;

   logic [1:0]        op_a_s  [NREQ];
   logic [3:0]        src_a_s [NREQ];
   logic [3:0]        dst_a_s [NREQ];
   logic [10:0]       amt_a_s [NREQ];

   logic              found_s;
   logic [PW-1:0]     cand_s;
   logic [PW-1:0]     win_s;
   logic [PW-1:0]     nxt_ptr_s;

   logic              src_ok_s;
   logic              dst_ok_s;
   logic [16:0]       debit_s;
   logic [15:0]       credit_base_s;
   logic [16:0]       sum_s;
   logic [2:0]        code_s;
   logic [15:0]       new_src_s;

   function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
      return {{(NREQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign op_a_s[g]  = bus.op[2*g +: 2];
      assign src_a_s[g] = bus.src_idx[4*g +: 4];
      assign dst_a_s[g] = bus.dst_idx[4*g +: 4];
      assign amt_a_s[g] = bus.amount[11*g +: 11];
   end

   // Pick the first requester at or after the round-robin pointer.
   always_comb begin
      found_s = 1'b0;
      cand_s  = '0;
      win_s   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_s = PW'((int'(rr_ptr_r) + k) % NREQ);
         if (!found_s && bus.req[cand_s]) begin
            found_s = 1'b1;
            win_s   = cand_s;
         end else begin
            found_s = found_s;
         end
      end
      nxt_ptr_s = PW'((int'(win_s) + 1) % NREQ);
   end

   // Error evaluation and new balances, meaningful in EXEC (mem_rdata then holds dst balance).
   always_comb begin
      src_ok_s      = ({1'b0, src_r} < 5'(NACC));
      dst_ok_s      = ({1'b0, dst_r} < 5'(NACC));
      if (op_r == OP_WD || op_r == OP_XFR) begin
         debit_s = 17'(amt_r) + FEE_AMT;
      end else begin
         debit_s = 17'(amt_r);
      end
      credit_base_s = (op_r == OP_XFR) ? bus.mem_rdata : src_bal_r;
      sum_s         = 17'(credit_base_s) + 17'(amt_r);

      if (!src_ok_s || (op_r == OP_XFR && !dst_ok_s)) begin
         code_s = RC_BAD_IDX;
      end else if (op_r == OP_XFR && src_r == dst_r) begin
         code_s = RC_SAME_ACC;
      end else if ((op_r == OP_WD || op_r == OP_XFR) && debit_s > 17'(src_bal_r)) begin
         code_s = RC_NO_FUNDS;
      end else if ((op_r == OP_DEP || op_r == OP_XFR) && sum_s[16]) begin
         code_s = RC_OVERFLOW;
      end else begin
         code_s = RC_OK;
      end

      case (op_r)
         OP_WD, OP_XFR: new_src_s = src_bal_r - debit_s[15:0];
         OP_DEP:        new_src_s = sum_s[15:0];
         default:       new_src_s = src_bal_r;
      endcase
   end

   // Main sequencer: arbitration, read-modify-write stepping and registered responses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         rr_ptr_r       <= '0;
         win_r          <= '0;
         op_r           <= 2'd0;
         src_r          <= 4'd0;
         dst_r          <= 4'd0;
         amt_r          <= 11'd0;
         src_bal_r      <= 16'd0;
         new_src_r      <= 16'd0;
         new_dst_r      <= 16'd0;
         gnt_r          <= '0;
         done_r         <= '0;
         resp_code_r    <= 3'd0;
         resp_balance_r <= 16'd0;
         busy_r         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= '0;
               if (found_s) begin
                  win_r    <= win_s;
                  op_r     <= op_a_s[win_s];
                  src_r    <= src_a_s[win_s];
                  dst_r    <= dst_a_s[win_s];
                  amt_r    <= amt_a_s[win_s];
                  rr_ptr_r <= nxt_ptr_s;
                  gnt_r    <= onehot(win_s);
                  busy_r   <= 1'b1;
                  state_r  <= ST_RD_SRC;
               end else begin
                  gnt_r    <= '0;
                  busy_r   <= 1'b0;
                  state_r  <= ST_IDLE;
               end
            end
            ST_RD_SRC: begin
               gnt_r   <= '0;
               state_r <= ST_RD_DST;
            end
            ST_RD_DST: begin
               src_bal_r <= bus.mem_rdata;
               state_r   <= ST_EXEC;
            end
            ST_EXEC: begin
               new_src_r <= new_src_s;
               new_dst_r <= sum_s[15:0];
               if (code_s != RC_OK || op_r == OP_BAL) begin
                  done_r      <= onehot(win_r);
                  resp_code_r <= code_s;
                  if (code_s == RC_BAD_IDX) begin
                     resp_balance_r <= 16'd0;
                  end else if (code_s == RC_OK) begin
                     resp_balance_r <= new_src_s;
                  end else begin
                     resp_balance_r <= src_bal_r;
                  end
                  state_r <= ST_RESP;
               end else begin
                  state_r <= ST_WR_SRC;
               end
            end
            ST_WR_SRC: begin
               if (op_r == OP_XFR) begin
                  state_r <= ST_WR_DST;
               end else begin
                  done_r         <= onehot(win_r);
                  resp_code_r    <= RC_OK;
                  resp_balance_r <= new_src_r;
                  state_r        <= ST_RESP;
               end
            end
            ST_WR_DST: begin
               done_r         <= onehot(win_r);
               resp_code_r    <= RC_OK;
               resp_balance_r <= new_src_r;
               state_r        <= ST_RESP;
            end
            ST_RESP: begin
               done_r  <= '0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               gnt_r   <= '0;
               done_r  <= '0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Memory strobes decode from state; held low while reset is asserted so an abandoned op writes nothing.
   always_comb begin
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = 4'd0;
      bus.mem_wdata = 16'd0;
      if (rst_n) begin
         case (state_r)
            ST_RD_SRC: begin
               if (src_ok_s) begin
                  bus.mem_rd   = 1'b1;
                  bus.mem_addr = src_r;
               end else begin
                  bus.mem_rd   = 1'b0;
               end
            end
            ST_RD_DST: begin
               if (op_r == OP_XFR && dst_ok_s) begin
                  bus.mem_rd   = 1'b1;
                  bus.mem_addr = dst_r;
               end else begin
                  bus.mem_rd   = 1'b0;
               end
            end
            ST_WR_SRC: begin
               bus.mem_wr    = 1'b1;
               bus.mem_addr  = src_r;
               bus.mem_wdata = new_src_r;
            end
            ST_WR_DST: begin
               bus.mem_wr    = 1'b1;
               bus.mem_addr  = dst_r;
               bus.mem_wdata = new_dst_r;
            end
            default: begin
               bus.mem_rd = 1'b0;
            end
         endcase
      end else begin
         bus.mem_rd = 1'b0;
      end
   end

   assign bus.gnt          = gnt_r;
   assign bus.done         = done_r;
   assign bus.resp_code    = resp_code_r;
   assign bus.resp_balance = resp_balance_r;
   assign bus.busy         = busy_r;

endmodule

// File: tb/tb_txn_scheduler.sv
// Self-checking bench for txn_scheduler: directed cases plus randomized traffic against a
// transaction-level model of the account balances.
module tb_txn_scheduler;

   localparam int NREQ = 2;
   localparam int NACC = 10;
   localparam int FEE  = 2;
`ifdef TXN_FEE_EN
   localparam int FEE_EFF = FEE;
`else
   localparam int FEE_EFF = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   txn_scheduler_if #(.NREQ(NREQ)) bus ();

   txn_scheduler #(.NREQ(NREQ), .NACC(NACC), .FEE(FEE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [NREQ-1:0] t_req;
   logic [1:0]      t_op  [NREQ];
   logic [3:0]      t_src [NREQ];
   logic [3:0]      t_dst [NREQ];
   logic [10:0]     t_amt [NREQ];

   always_comb begin
      bus.req = t_req;
      for (int i = 0; i < NREQ; i++) begin
         bus.op[2*i +: 2]       = t_op[i];
         bus.src_idx[4*i +: 4]  = t_src[i];
         bus.dst_idx[4*i +: 4]  = t_dst[i];
         bus.amount[11*i +: 11] = t_amt[i];
      end
   end

   // Balance store: one-cycle read latency, plus a backdoor port for preloading.
   logic [15:0] mem [16];
   logic        bd_we = 1'b0;
   logic [3:0]  bd_addr = 4'd0;
   logic [15:0] bd_data = 16'd0;
   int          wr_cnt = 0;

   always @(posedge clk) begin
      if (!rst_n) bus.mem_rdata <= 16'd0;
      else if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_wr) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end else if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end
   end

   int   ref_mem [16];
   logic ref_ptr;
   int   last_gc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic backdoor(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
      ref_mem[a] = int'(d);
   endtask

   // Transaction-level outcome of one operation; updates the model balances on success.
   task automatic ref_txn(input logic [1:0] o, input logic [3:0] s, input logic [3:0] d,
                          input logic [10:0] a, output int code, output int bal,
                          output int lat, output int nwr);
      int debit, sb, db;
      debit = int'(a) + (((o == 2'd1) || (o == 2'd3)) ? FEE_EFF : 0);
      sb = ref_mem[s];
      db = ref_mem[d];
      lat = 3; nwr = 0;
      if (int'(s) >= NACC || (o == 2'd3 && int'(d) >= NACC)) begin
         code = 1; bal = 0;
      end else if (o == 2'd3 && s == d) begin
         code = 4; bal = sb;
      end else if ((o == 2'd1 || o == 2'd3) && debit > sb) begin
         code = 2; bal = sb;
      end else if (o == 2'd2 && sb + int'(a) > 65535) begin
         code = 3; bal = sb;
      end else if (o == 2'd3 && db + int'(a) > 65535) begin
         code = 3; bal = sb;
      end else begin
         code = 0;
         case (o)
            2'd1: begin bal = sb - debit; ref_mem[s] = bal; lat = 4; nwr = 1; end
            2'd2: begin bal = sb + int'(a); ref_mem[s] = bal; lat = 4; nwr = 1; end
            2'd3: begin
               bal = sb - debit; ref_mem[s] = bal; ref_mem[d] = db + int'(a);
               lat = 5; nwr = 2;
            end
            default: bal = sb;
         endcase
      end
   endtask

   task automatic set_req(input logic r, input logic [1:0] o, input logic [3:0] s,
                          input logic [3:0] d, input logic [10:0] a);
      t_op[r] = o; t_src[r] = s; t_dst[r] = d; t_amt[r] = a; t_req[r] = 1'b1;
   endtask

   // Wait for requester r to be granted, then follow the operation to its done pulse.
   task automatic serve(input logic r);
      int n, code, bal, lat, nwr, w0;
      logic [NREQ-1:0] g;
      logic [1:0] o; logic [3:0] s, d; logic [10:0] a;
      logic [NREQ-1:0] exp_oh;
      o = t_op[r]; s = t_src[r]; d = t_dst[r]; a = t_amt[r];
      exp_oh = 2'b01 << r;
      g = '0; n = 0;
      while (n < 50 && g == '0) begin
         @(negedge clk);
         g = bus.gnt;
         n++;
      end
      last_gc = cyc;
      check("gnt_onehot", 32'(g), 32'(exp_oh));
      check("busy_at_gnt", 32'(bus.busy), 32'd1);
      t_req[r] = 1'b0;
      ref_ptr = ~r;
      w0 = wr_cnt;
      ref_txn(o, s, d, a, code, bal, lat, nwr);
      g = '0; n = 0;
      while (n < 12 && g == '0) begin
         @(negedge clk);
         n++;
         g = bus.done;
      end
      check("done_onehot", 32'(g), 32'(exp_oh));
      check("latency", 32'(n), 32'(lat));
      check("resp_code", 32'(bus.resp_code), 32'(code));
      check("resp_balance", 32'(bus.resp_balance), 32'(bal));
      check("write_count", 32'(wr_cnt - w0), 32'(nwr));
      check("mem_src", 32'(mem[s]), 32'(ref_mem[s]));
      if (o == 2'd3) check("mem_dst", 32'(mem[d]), 32'(ref_mem[d]));
   endtask

   task automatic single(input logic r, input logic [1:0] o, input logic [3:0] s,
                         input logic [3:0] d, input logic [10:0] a);
      @(negedge clk);
      set_req(r, o, s, d, a);
      serve(r);
   endtask

   initial begin
      int g0, n;
      logic [NREQ-1:0] g;
      logic w;
      t_req = '0;
      for (int i = 0; i < NREQ; i++) begin
         t_op[i] = 2'd0; t_src[i] = 4'd0; t_dst[i] = 4'd0; t_amt[i] = 11'd0;
      end
      for (int i = 0; i < 16; i++) ref_mem[i] = 0;
      ref_ptr = 1'b0;
      last_gc = 0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctrl", 32'({bus.gnt, bus.done, bus.resp_code, bus.busy,
                             bus.mem_rd, bus.mem_wr, bus.mem_addr}), 32'd0);
      check("rst_data", {bus.resp_balance, bus.mem_wdata}, 32'd0);
      for (int i = 0; i < 16; i++) backdoor(4'(i), 16'd500);
      rst_n = 1'b1;

      // Simultaneous transfers right after reset: requester 0 first.
      @(negedge clk);
      set_req(1'b0, 2'd3, 4'd2, 4'd5, 11'd100);
      set_req(1'b1, 2'd3, 4'd5, 4'd2, 11'd600);
      serve(1'b0);
      g0 = last_gc;
      serve(1'b1);
      check("pair_gap_ge7", 32'((last_gc - g0) >= 7), 32'd1);
      check("pair_mem2", 32'(mem[2]), 32'd1000);
      check("pair_mem5", 32'(mem[5]), 32'd0);

      single(1'b0, 2'd1, 4'd3, 4'd0, 11'd120);
      check("wd_mem3", 32'(mem[3]), 32'd380);
      single(1'b1, 2'd1, 4'd7, 4'd0, 11'd501);
      single(1'b0, 2'd3, 4'd1, 4'd12, 11'd10);
      single(1'b1, 2'd3, 4'd4, 4'd4, 11'd10);
      backdoor(4'd0, 16'd65500);
      single(1'b0, 2'd2, 4'd0, 4'd0, 11'd100);
      single(1'b1, 2'd0, 4'd3, 4'd0, 11'd0);
      single(1'b0, 2'd0, 4'd10, 4'd0, 11'd0);
      single(1'b1, 2'd1, 4'd8, 4'd0, 11'd0);
      single(1'b0, 2'd1, 4'd9, 4'd0, 11'd500);
      backdoor(4'd1, 16'd500);
      single(1'b1, 2'd1, 4'd1, 4'd0, 11'd498);
      backdoor(4'd1, 16'd500);
      single(1'b0, 2'd1, 4'd1, 4'd0, 11'd499);
      single(1'b1, 2'd2, 4'd15, 4'd0, 11'd5);

      // Randomized traffic, sometimes with both requesters contending.
      for (int it = 0; it < 30; it++) begin
         @(negedge clk);
         for (int r = 0; r < NREQ; r++) begin
            t_op[r]  = 2'($urandom_range(0, 3));
            t_src[r] = 4'($urandom_range(0, 11));
            t_dst[r] = 4'($urandom_range(0, 11));
            t_amt[r] = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                                   : 11'($urandom_range(0, 300));
         end
         if ($urandom_range(0, 2) == 0) begin
            w = ref_ptr;
            t_req = 2'b11;
            serve(w);
            serve(~w);
         end else begin
            w = 1'($urandom_range(0, 1));
            t_req[w] = 1'b1;
            serve(w);
         end
      end

      // Reset during the source write of a transfer abandons it cleanly.
      @(negedge clk);
      set_req(1'b0, 2'd3, 4'd1, 4'd6, 11'd10);
      g = '0; n = 0;
      while (n < 50 && g == '0) begin
         @(negedge clk);
         g = bus.gnt;
         n++;
      end
      check("abort_gnt", 32'(g), 32'd1);
      t_req[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_wr_src_seen", 32'(bus.mem_wr), 32'd1);
      g0 = wr_cnt;
      rst_n = 1'b0;
      #1;
      check("abort_wr_gated", 32'(bus.mem_wr), 32'd0);
      @(negedge clk);
      check("abort_rst_ctrl", 32'({bus.gnt, bus.done, bus.resp_code, bus.busy,
                                   bus.mem_rd, bus.mem_wr, bus.mem_addr}), 32'd0);
      check("abort_rst_data", {bus.resp_balance, bus.mem_wdata}, 32'd0);
      repeat (2) @(negedge clk);
      check("abort_no_write", 32'(wr_cnt - g0), 32'd0);
      check("abort_mem1", 32'(mem[1]), 32'(ref_mem[1]));
      check("abort_mem6", 32'(mem[6]), 32'(ref_mem[6]));
      rst_n = 1'b1;
      ref_ptr = 1'b0;
      @(negedge clk);
      set_req(1'b0, 2'd2, 4'd6, 4'd0, 11'd7);
      set_req(1'b1, 2'd2, 4'd1, 4'd0, 11'd3);
      serve(1'b0);
      serve(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/txn_scheduler.md
# txn_scheduler

Shared-balance transaction scheduler for the bill-payment/ATM subsystem. Arbitrates round-robin between `NREQ` terminal requesters and sequences each accepted balance, withdraw, deposit or transfer as read-modify-write on a single-port balance memory holding `NACC` 16-bit accounts. Operations are atomic with respect to other requesters and return a status code and resulting balance. It sits between the per-terminal session logic and the balance store.

## Interface
- `NREQ`, 2: number of requesters (2..4).
- `NACC`, 10: number of valid accounts; valid indices are 0..NACC-1.
- `FEE`, 2: fixed charge used only when `TXN_FEE_EN` is defined.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in NREQ: per-requester request level.
- `op` in 2*NREQ: per-requester opcode. 00 BALANCE, 01 WITHDRAW, 10 DEPOSIT, 11 TRANSFER.
- `src_idx` in 4*NREQ: per-requester source or own account index.
- `dst_idx` in 4*NREQ: per-requester destination index; TRANSFER only.
- `amount` in 11*NREQ: per-requester amount, unsigned.
- `gnt` out NREQ: one-hot, one-cycle pulse; operands were captured.
- `done` out NREQ: one-hot, one-cycle completion pulse.
- `resp_code` out 3: status, valid while `done`. 0 OK, 1 BAD_IDX, 2 NO_FUNDS, 3 OVERFLOW, 4 SAME_ACC.
- `resp_balance` out 16: source balance, valid while `done`.
- `busy` out 1: high in every non-IDLE state.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `mem_addr` out 4: memory address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: read data, valid in the cycle after `mem_rd`.

## Operation
- **States:** IDLE, RD_SRC, RD_DST, EXEC, WR_SRC, WR_DST, RESP.
- **IDLE, with any `req` high:**
  - Winner is the first requester at or after the RR pointer.
  - Latch the winner's operands and move to RD_SRC.
  - `gnt[w]` is high during the first RD_SRC cycle.
  - RR pointer becomes w+1 mod NREQ.
- **RD_SRC:** `mem_rd`=1 and `mem_addr`=src, only if src < NACC. Then go to RD_DST.
- **RD_DST:**
  - Capture `mem_rdata` as src_bal.
  - For TRANSFER with dst < NACC: `mem_rd`=1 and `mem_addr`=dst.
  - Then go to EXEC.
- **EXEC:**
  - Capture `mem_rdata` as dst_bal (TRANSFER only).
  - Evaluate errors in priority order:
    - BAD_IDX: src ≥ NACC, or, for TRANSFER, dst ≥ NACC.
    - SAME_ACC: TRANSFER with src == dst.
    - NO_FUNDS: debit > src_bal.
    - OVERFLOW: 17-bit credited sum > 65535.
  - On error, or for BALANCE: go to RESP.
  - Otherwise: go to WR_SRC.
- **Arithmetic:**
  - debit = amount, zero-extended.
  - WITHDRAW: src −= debit.
  - DEPOSIT: src += amount.
  - TRANSFER: src −= debit, dst += amount.
- **WR_SRC:** `mem_wr`=1, `mem_addr`=src, `mem_wdata`=new src balance. Next state is WR_DST for TRANSFER, otherwise RESP.
- **WR_DST:** `mem_wr`=1, `mem_addr`=dst, `mem_wdata`=new dst balance. Then go to RESP.
- **RESP:**
  - `done[w]`=1 with `resp_code`.
  - `resp_balance` = post-op src balance on OK; pre-op src_bal on error; 0 on BAD_IDX.
  - Then go to IDLE.
- **On error, no memory write occurs.**
- **`mem_*` signals decode combinationally from state.** They are 0 in IDLE, EXEC and RESP.
- **Requester handshake:**
  - Hold `req` and operands stable until `gnt`.
  - Dropping `req` before `gnt` withdraws the request.
  - `req` is ignored while `busy`.
  - `req` still high when the block returns to IDLE is treated as a new request.

## Timing
- **Reset values:** `gnt`, `done`, `resp_code`, `resp_balance`, `busy` and `mem_*` are all 0. State is IDLE and the RR pointer is 0.
- **Latency, counted from the `gnt` cycle (cycle 0):**
  - `done` at cycle 3 for BALANCE and any error.
  - `done` at cycle 4 for WITHDRAW and DEPOSIT.
  - `done` at cycle 5 for TRANSFER.
- **Back-to-back:** at least one IDLE cycle between `done` and the next `gnt`.
- **Simultaneous requests:** exactly one `gnt`. The loser stays pending and is served next if it is still requesting.
- **Reset mid-operation:** abandons immediately, with no further writes. Reset asserted during WR_DST after WR_SRC leaves a half-applied transfer; this is accepted and documented.
- **Boundaries:**
  - amount = 0 is legal, OK, and writes an unchanged value.
  - amount == src_bal is OK, with a result of 0.

## Configuration
- **`TXN_FEE_EN` defined:** for WITHDRAW and TRANSFER, debit = amount + FEE. The NO_FUNDS check and the source write use this debit. The fee is not credited anywhere. DEPOSIT and BALANCE are unaffected.
- **`TXN_FEE_EN` undefined:** debit = amount and `FEE` is ignored.

## Test plan
- Memory preloaded with 500 per account, no fee. Requester 0 issues WITHDRAW src=3, amount=120 → `gnt[0]` at cycle 0, `done[0]` at cycle 4, code 0, `resp_balance`=380, mem[3]=380.
- Requester 0 and requester 1 both issue TRANSFER in the same cycle after reset → requester 0 granted first, requester 1 granted at least 7 cycles later. Requester 0 (2→5, 100): mem[2]=400, mem[5]=600. Requester 1 (5→2, 600): OK, mem[5]=0, mem[2]=1000.
- WITHDRAW amount=501 on a 500 balance → code 2 at cycle 3, `resp_balance`=500, `mem_wr` never asserted.
- TRANSFER with dst=12 → code 1. TRANSFER with src=dst=4 → code 4. DEPOSIT 100 onto mem[0]=65500 → code 3.
- With `TXN_FEE_EN` and FEE=2: WITHDRAW 498 from 500 → OK with balance 0. WITHDRAW 499 from 500 → NO_FUNDS.
- `rst_n` low during WR_SRC of a TRANSFER → no write that cycle or after, outputs at reset values. A fresh request after reset is granted to requester 0.
